// File: rtl/updn_ctr_pkg.sv
// ============================================================================
// updn_ctr_pkg
// Shared constants for the up/down counter: mode encodings and the default
// terminal value helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package updn_ctr_pkg;

    localparam int CTR_WRAP = 0;
    localparam int CTR_SAT  = 1;

    // All-ones value for a given width; a 33-bit intermediate keeps WIDTH=32 exact.
    function automatic int unsigned default_max_val(input int unsigned width);
        logic [32:0] all_ones;
        all_ones = (33'd1 << width) - 33'd1;
        return all_ones[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/updn_ctr_next.sv
// ============================================================================
// updn_ctr_next
// Combinational next-count and terminal-step calculator for updn_ctr_mod.
// Rev 1.0
// ============================================================================
`default_nettype none

module updn_ctr_next
    import updn_ctr_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = default_max_val(WIDTH),
    parameter int          SATURATE = CTR_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             cen,
    output logic [WIDTH-1:0] next_count,
    output logic             term_step
);

    localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

    // Landing value for a terminal step: stay put when saturating, else jump to the far end.
    localparam logic [WIDTH-1:0] UP_TERM_NEXT   = (SATURATE == CTR_SAT) ? MAX_C : '0;
    localparam logic [WIDTH-1:0] DOWN_TERM_NEXT = (SATURATE == CTR_SAT) ? '0    : MAX_C;

    always_comb begin
        next_count = count;
        term_step  = 1'b0;
        if (cen) begin
            if (up_dn) begin
                if (count == MAX_C) begin
                    next_count = UP_TERM_NEXT;
                    term_step  = 1'b1;
                end else begin
                    next_count = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    next_count = DOWN_TERM_NEXT;
                    term_step  = 1'b1;
                end else begin
                    next_count = count - 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/updn_ctr_mod.sv
// ============================================================================
// updn_ctr_mod
// Up/down counter with synchronous load, programmable modulus, wrap or
// saturate mode, terminal-count flag, wrap pulse and sticky overflow.
// Rev 1.0
// ============================================================================
`default_nettype none

module updn_ctr_mod
    import updn_ctr_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = default_max_val(WIDTH),
    parameter int          SATURATE = CTR_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             cen,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tercnt,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [32:0]      WIDTH_LIMIT = (33'd1 << WIDTH) - 33'd1;
    localparam logic [WIDTH-1:0] MAX_C       = MAX_VAL[WIDTH-1:0];

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updn_ctr_mod: WIDTH must be 2..32");
    end

    if (MAX_VAL < 1 || {1'b0, MAX_VAL} > WIDTH_LIMIT) begin : g_bad_max_val
        $error("updn_ctr_mod: MAX_VAL must be 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] w_next_count;
    logic             w_term_step;
    logic [WIDTH-1:0] w_load_val;

    updn_ctr_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .up_dn      (up_dn),
        .cen        (cen),
        .next_count (w_next_count),
        .term_step  (w_term_step)
    );

    // Clamp keeps a loaded value inside 0..MAX_VAL so the range invariant holds.
    assign w_load_val = (data > MAX_C) ? MAX_C : data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= w_load_val;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= w_next_count;
            wrap  <= w_term_step;
            if (w_term_step) begin
                ovf <= 1'b1;
            end
        end
    end

    assign tercnt = up_dn ? (count == MAX_C) : (count == '0);

endmodule

`default_nettype wire

// File: tb/tb_updn_ctr_mod.sv
// ============================================================================
// tb_updn_ctr_mod
// Directed bench for updn_ctr_mod covering wrap, saturate and 4-bit configs.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_updn_ctr_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // a: WIDTH=8 MAX_VAL=9 wrap; b: WIDTH=8 MAX_VAL=9 saturate; c: WIDTH=4 MAX_VAL=15 wrap
    logic       a_reset, a_load, a_cen, a_up_dn, a_tercnt, a_wrap, a_ovf;
    logic [7:0] a_data, a_count;
    logic       b_reset, b_load, b_cen, b_up_dn, b_tercnt, b_wrap, b_ovf;
    logic [7:0] b_data, b_count;
    logic       c_reset, c_load, c_cen, c_up_dn, c_tercnt, c_wrap, c_ovf;
    logic [3:0] c_data, c_count;

    updn_ctr_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(0)) dut_a (
        .clk(clk), .reset(a_reset), .load(a_load), .data(a_data), .cen(a_cen),
        .up_dn(a_up_dn), .count(a_count), .tercnt(a_tercnt), .wrap(a_wrap), .ovf(a_ovf)
    );

    updn_ctr_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1)) dut_b (
        .clk(clk), .reset(b_reset), .load(b_load), .data(b_data), .cen(b_cen),
        .up_dn(b_up_dn), .count(b_count), .tercnt(b_tercnt), .wrap(b_wrap), .ovf(b_ovf)
    );

    updn_ctr_mod #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0)) dut_c (
        .clk(clk), .reset(c_reset), .load(c_load), .data(c_data), .cen(c_cen),
        .up_dn(c_up_dn), .count(c_count), .tercnt(c_tercnt), .wrap(c_wrap), .ovf(c_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        a_reset = 0; a_load = 0; a_data = 0; a_cen = 0; a_up_dn = 1;
        b_reset = 0; b_load = 0; b_data = 0; b_cen = 0; b_up_dn = 1;
        c_reset = 0; c_load = 0; c_data = 0; c_cen = 0; c_up_dn = 1;

        // Reset held two cycles on all instances
        tick(); tick();
        chk("a_reset_count", a_count, 0);
        chk("a_reset_wrap", a_wrap, 0);
        chk("a_reset_ovf", a_ovf, 0);
        chk("a_reset_tercnt_up", a_tercnt, 0);
        chk("c_reset_count", c_count, 0);

        // Wrap-mode up count through 9 -> 0
        a_reset = 1; a_cen = 1; a_up_dn = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("a_up_count_%0d", i), a_count, exp_cnt[i]);
            chk($sformatf("a_up_wrap_%0d", i), a_wrap, (i == 9) ? 1 : 0);
            chk($sformatf("a_up_tercnt_%0d", i), a_tercnt, (i == 8) ? 1 : 0);
            chk($sformatf("a_up_ovf_%0d", i), a_ovf, (i >= 9) ? 1 : 0);
        end

        // Sticky ovf survives idle cycles
        a_cen = 0;
        tick();
        chk("a_idle_count", a_count, 2);
        chk("a_idle_ovf", a_ovf, 1);
        chk("a_idle_wrap", a_wrap, 0);

        // Down count from reset: 0 -> 9 -> 8
        a_reset = 0;
        tick();
        chk("a_rst2_ovf", a_ovf, 0);
        a_reset = 1; a_cen = 1; a_up_dn = 0;
        #1;
        chk("a_dn_tercnt_at0", a_tercnt, 1);
        tick();
        chk("a_dn_count_1", a_count, 9);
        chk("a_dn_wrap_1", a_wrap, 1);
        chk("a_dn_ovf_1", a_ovf, 1);
        chk("a_dn_tercnt_1", a_tercnt, 0);
        tick();
        chk("a_dn_count_2", a_count, 8);
        chk("a_dn_wrap_2", a_wrap, 0);
        chk("a_dn_ovf_2", a_ovf, 1);

        // Saturate mode: load 7 then five up steps
        b_reset = 1; b_load = 1; b_data = 7;
        tick();
        chk("b_load7_count", b_count, 7);
        b_load = 0; b_cen = 1; b_up_dn = 1;
        tick(); chk("b_sat_count_0", b_count, 8); chk("b_sat_wrap_0", b_wrap, 0);
        tick(); chk("b_sat_count_1", b_count, 9); chk("b_sat_wrap_1", b_wrap, 0);
        chk("b_sat_ovf_1", b_ovf, 0);
        tick(); chk("b_sat_count_2", b_count, 9); chk("b_sat_wrap_2", b_wrap, 1);
        chk("b_sat_ovf_2", b_ovf, 1);
        tick(); chk("b_sat_count_3", b_count, 9); chk("b_sat_wrap_3", b_wrap, 1);
        tick(); chk("b_sat_count_4", b_count, 9); chk("b_sat_wrap_4", b_wrap, 1);
        chk("b_sat_ovf_4", b_ovf, 1);

        // Load beyond MAX_VAL clamps and clears the flags
        b_load = 1; b_data = 200; b_cen = 0;
        tick();
        chk("b_clamp_count", b_count, 9);
        chk("b_clamp_ovf", b_ovf, 0);
        chk("b_clamp_wrap", b_wrap, 0);

        // Saturate at 0 on the way down
        b_data = 1;
        tick();
        b_load = 0; b_cen = 1; b_up_dn = 0;
        tick(); chk("b_dn_count_0", b_count, 0); chk("b_dn_wrap_0", b_wrap, 0);
        tick(); chk("b_dn_count_1", b_count, 0); chk("b_dn_wrap_1", b_wrap, 1);
        chk("b_dn_ovf_1", b_ovf, 1);

        // Load beats count enable
        a_load = 1; a_data = 5; a_cen = 0;
        tick();
        chk("a_load5_count", a_count, 5);
        a_data = 3; a_cen = 1; a_up_dn = 1;
        tick();
        chk("a_load_vs_cen_count", a_count, 3);
        chk("a_load_vs_cen_wrap", a_wrap, 0);
        a_reset = 0; a_data = 7;
        tick();
        chk("a_rst_vs_load_count", a_count, 0);
        chk("a_rst_vs_load_ovf", a_ovf, 0);
        a_reset = 1; a_load = 0; a_cen = 0;

        // 4-bit counter: reset mid-count at 14
        c_reset = 1; c_load = 1; c_data = 14;
        tick();
        chk("c_load14_count", c_count, 14);
        c_load = 0; c_cen = 1; c_up_dn = 1; c_reset = 0;
        tick();
        chk("c_midrst_count", c_count, 0);
        chk("c_midrst_wrap", c_wrap, 0);
        c_reset = 1;
        tick(); chk("c_resume_1", c_count, 1);
        tick(); chk("c_resume_2", c_count, 2);

        // 4-bit natural-range wrap 15 -> 0
        c_load = 1; c_data = 15;
        tick();
        c_load = 0;
        #1;
        chk("c_tercnt_15", c_tercnt, 1);
        tick();
        chk("c_wrap_count", c_count, 0);
        chk("c_wrap_pulse", c_wrap, 1);
        chk("c_wrap_ovf", c_ovf, 1);

        // tercnt follows up_dn combinationally with cen low
        c_cen = 0; c_up_dn = 1;
        tick();
        chk("c_hold_wrap", c_wrap, 0);
        chk("c_tercnt_up_at0", c_tercnt, 0);
        c_up_dn = 0;
        #1;
        chk("c_tercnt_dn_at0", c_tercnt, 1);
        tick();
        chk("c_hold_count", c_count, 0);
        chk("c_hold_ovf", c_ovf, 1);
        c_up_dn = 1;
        #1;
        chk("c_tercnt_up_again", c_tercnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
